// File: rtl/hps_link_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coproc_pkg
// Purpose  : Shared constants and types for the HPS-side coprocessor link
//            master. It holds the matrix word count, the register address map
//            and the link state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package coproc_pkg;

  // One 5x5x8-bit matrix is packed into seven 32-bit words.
  localparam int unsigned WORDS = 7;
  // Width of a word index inside a bank. The address map leaves 8 slots per bank.
  localparam int unsigned IDX_W = 3;

  // Register address map (5-bit host address).
  localparam logic [4:0] ADDR_A_BASE = 5'd0;
  localparam logic [4:0] ADDR_B_BASE = 5'd8;
  localparam logic [4:0] ADDR_CTRL   = 5'd16;
  localparam logic [4:0] ADDR_STATUS = 5'd17;
  localparam logic [4:0] ADDR_R_BASE = 5'd24;

  // Address bits [4:3] select the 8-entry region.
  localparam logic [1:0] REGION_A   = ADDR_A_BASE[4:3];
  localparam logic [1:0] REGION_B   = ADDR_B_BASE[4:3];
  localparam logic [1:0] REGION_CSR = ADDR_CTRL[4:3];
  localparam logic [1:0] REGION_R   = ADDR_R_BASE[4:3];

  typedef enum logic [2:0] {
    LS_IDLE       = 3'd0,
    LS_ANNOUNCE   = 3'd1,
    LS_SEND       = 3'd2,
    LS_WAIT_READY = 3'd3,
    LS_START      = 3'd4,
    LS_COLLECT    = 3'd5,
    LS_WAIT_DONE  = 3'd6
  } link_state_t;

endpackage
`default_nettype wire

// File: rtl/hps_link_master_if.sv
`default_nettype none
// ============================================================================
// Module   : hps_link_master_if
// Purpose  : Bundles the host register port and the coprocessor link signals.
// Ports    : host_wr/host_rd/host_addr/host_wdata -> master, host_rdata <- master
//            matrix1_data/matrix2_data/instruction/save_data/start/hps_busy
//            <- master; fpga_wait/fpga_ready/result_data/result_valid/
//            processing_done -> master.
//            modport master = link master side, modport slave = host + receiver.
// Revision : 1.0  initial release
// ============================================================================
interface hps_link_master_if;
  logic        host_wr;
  logic        host_rd;
  logic [4:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;

  logic [31:0] matrix1_data;
  logic [31:0] matrix2_data;
  logic [5:0]  instruction;
  logic        save_data;
  logic        start;
  logic        hps_busy;

  logic        fpga_wait;
  logic        fpga_ready;
  logic [31:0] result_data;
  logic        result_valid;
  logic        processing_done;

  modport master (
    input  host_wr, host_rd, host_addr, host_wdata,
    output host_rdata,
    output matrix1_data, matrix2_data, instruction, save_data, start, hps_busy,
    input  fpga_wait, fpga_ready, result_data, result_valid, processing_done
  );

  modport slave (
    output host_wr, host_rd, host_addr, host_wdata,
    input  host_rdata,
    input  matrix1_data, matrix2_data, instruction, save_data, start, hps_busy,
    output fpga_wait, fpga_ready, result_data, result_valid, processing_done
  );
endinterface
`default_nettype wire

// File: rtl/hps_link_master_word_bank.sv
`default_nettype none
// ============================================================================
// Module   : word_bank
// Purpose  : DEPTH x WIDTH register file with one synchronous write port, one
//            asynchronous read port and an asynchronous clear on rst.
//            Out-of-range read addresses return 0; out-of-range writes are
//            dropped.
// Ports    : clk, rst       clock / async active-high clear
//            we_i, waddr_i, wdata_i   write port
//            raddr_i, rdata_o         combinational read port
// Revision : 1.0  initial release
// ============================================================================
module word_bank #(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i <= LAST)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i <= LAST) ? mem_q[raddr_i] : '0;

endmodule
`default_nettype wire

// File: rtl/hps_link_master.sv
`default_nettype none
// ============================================================================
// Module   : hps_link_master
// Purpose  : Host-side end of the HPS<->FPGA matrix coprocessor link. Holds
//            operand banks A and B and the result bank, and on a CTRL 'go'
//            streams the operands, pulses start, collects the results and
//            waits for processing_done, then reports status to the host.
// Ports    : clk  single clock
//            rst  asynchronous active-high reset
//            bus  hps_link_master_if.master (host register port + link)
// Revision : 1.0  initial release
// ============================================================================
module hps_link_master #(
  parameter int unsigned WORDS          = 7,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  hps_link_master_if.master bus
);
  import coproc_pkg::*;

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [2:0] S_IDLE       = LS_IDLE;
  localparam logic [2:0] S_ANNOUNCE   = LS_ANNOUNCE;
  localparam logic [2:0] S_SEND       = LS_SEND;
  localparam logic [2:0] S_WAIT_READY = LS_WAIT_READY;
  localparam logic [2:0] S_START      = LS_START;
  localparam logic [2:0] S_COLLECT    = LS_COLLECT;
  localparam logic [2:0] S_WAIT_DONE  = LS_WAIT_DONE;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [5:0]       opcode_q, opcode_d;
  logic             save_data_q, save_data_d;
  logic             start_q, start_d;
  logic             hps_busy_q, hps_busy_d;
  logic [31:0]      m1_q, m1_d;
  logic [31:0]      m2_q, m2_d;
  logic [5:0]       instr_q, instr_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [1:0]       w_region;
  logic [IDX_W-1:0] w_host_idx;
  logic             w_idx_ok;
  logic             w_busy;
  logic             w_go;
  logic             w_wr_a;
  logic             w_wr_b;
  logic             w_accept;
  logic             w_capture;
  logic             w_link_owns;
  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_ab_raddr;
  logic [31:0]      w_a_rdata;
  logic [31:0]      w_b_rdata;
  logic [31:0]      w_r_rdata;
  logic [31:0]      w_rdata;
  logic             w_tick;

  // --------------------------------------------------------------------------
  // Host register decode
  // --------------------------------------------------------------------------
  assign w_region   = bus.host_addr[4:3];
  assign w_host_idx = bus.host_addr[IDX_W-1:0];
  assign w_idx_ok   = (w_host_idx <= LAST_IDX);
  assign w_busy     = (state_q != S_IDLE);

  assign w_go   = bus.host_wr && !w_busy && (bus.host_addr == ADDR_CTRL) && bus.host_wdata[0];
  assign w_wr_a = bus.host_wr && !w_busy && (w_region == REGION_A) && w_idx_ok;
  assign w_wr_b = bus.host_wr && !w_busy && (w_region == REGION_B) && w_idx_ok;

  assign w_accept  = (state_q == S_SEND) && !bus.fpga_wait;
  assign w_capture = (state_q == S_COLLECT) && bus.result_valid;

  // The A/B read ports are shared: the link owns them from the go cycle until
  // the transaction ends, so host reads of A/B while busy return 0.
  assign w_link_owns = w_busy || w_go;

  // Index of the word the data outputs must carry after this edge.
  always_comb begin
    w_fetch_idx = idx_q;
    if (state_q == S_IDLE) begin
      w_fetch_idx = '0;
    end else if (w_accept && (idx_q != LAST_IDX)) begin
      w_fetch_idx = idx_q + 1'b1;
    end
  end

  assign w_ab_raddr = w_link_owns ? w_fetch_idx : w_host_idx;

  word_bank #(.DEPTH(WORDS), .WIDTH(32), .AW(IDX_W)) u_bank_a (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_wr_a),
    .waddr_i (w_host_idx),
    .wdata_i (bus.host_wdata),
    .raddr_i (w_ab_raddr),
    .rdata_o (w_a_rdata)
  );

  word_bank #(.DEPTH(WORDS), .WIDTH(32), .AW(IDX_W)) u_bank_b (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_wr_b),
    .waddr_i (w_host_idx),
    .wdata_i (bus.host_wdata),
    .raddr_i (w_ab_raddr),
    .rdata_o (w_b_rdata)
  );

  word_bank #(.DEPTH(WORDS), .WIDTH(32), .AW(IDX_W)) u_bank_r (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_capture),
    .waddr_i (ridx_q),
    .wdata_i (bus.result_data),
    .raddr_i (w_host_idx),
    .rdata_o (w_r_rdata)
  );

  // Host read mux
  always_comb begin
    w_rdata = '0;
    case (w_region)
      REGION_A: if (w_idx_ok && !w_link_owns) w_rdata = w_a_rdata;
      REGION_B: if (w_idx_ok && !w_link_owns) w_rdata = w_b_rdata;
      REGION_R: if (w_idx_ok) w_rdata = w_r_rdata;
      default: begin
        if (bus.host_addr == ADDR_CTRL) begin
          w_rdata = {25'd0, opcode_q, 1'b0};
        end else if (bus.host_addr == ADDR_STATUS) begin
          w_rdata = {29'd0, error_q, done_q, w_busy};
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Link state machine; every output is computed for the next state here and
  // registered below.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ridx_d      = ridx_q;
    timer_d     = timer_q;
    done_d      = done_q;
    error_d     = error_q;
    opcode_d    = opcode_q;
    save_data_d = save_data_q;
    start_d     = start_q;
    hps_busy_d  = hps_busy_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    instr_d     = instr_q;
    rdata_d     = bus.host_rd ? w_rdata : rdata_q;
    w_tick      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_go) begin
          opcode_d    = bus.host_wdata[6:1];
          instr_d     = bus.host_wdata[6:1];
          done_d      = 1'b0;
          error_d     = 1'b0;
          idx_d       = '0;
          timer_d     = '0;
          save_data_d = 1'b1;
          m1_d        = w_a_rdata;
          m2_d        = w_b_rdata;
          state_d     = S_ANNOUNCE;
        end
      end
      S_ANNOUNCE: begin
        // Word 0 is already on the outputs; it is presented again in SEND.
        timer_d = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (w_accept) begin
          timer_d = '0;
          if (idx_q == LAST_IDX) begin
            save_data_d = 1'b0;
            state_d     = S_WAIT_READY;
          end else begin
            idx_d = idx_q + 1'b1;
            m1_d  = w_a_rdata;
            m2_d  = w_b_rdata;
          end
        end else begin
          w_tick = 1'b1;
        end
      end
      S_WAIT_READY: begin
        if (bus.fpga_ready) begin
          timer_d    = '0;
          ridx_d     = '0;
          start_d    = 1'b1;
          hps_busy_d = 1'b0;
          state_d    = S_START;
        end else begin
          w_tick = 1'b1;
        end
      end
      S_START: begin
        timer_d = '0;
        start_d = 1'b0;
        state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_capture) begin
          timer_d = '0;
          ridx_d  = ridx_q + 1'b1;
          if (ridx_q == LAST_IDX) begin
            hps_busy_d = 1'b1;
            state_d    = S_WAIT_DONE;
          end
        end else begin
          w_tick = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (bus.processing_done) begin
          timer_d = '0;
          done_d  = 1'b1;
          instr_d = '0;
          state_d = S_IDLE;
        end else begin
          w_tick = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A cycle without progress in a wait state advances the watchdog; the
    // TIMEOUT_CYCLES-th such cycle in a row aborts the transaction.
    if (w_tick) begin
      if (timer_q == TMR_LAST) begin
        timer_d     = '0;
        error_d     = 1'b1;
        save_data_d = 1'b0;
        start_d     = 1'b0;
        hps_busy_d  = 1'b1;
        instr_d     = '0;
        state_d     = S_IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ridx_q      <= '0;
      timer_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      opcode_q    <= '0;
      save_data_q <= 1'b0;
      start_q     <= 1'b0;
      hps_busy_q  <= 1'b1;
      m1_q        <= '0;
      m2_q        <= '0;
      instr_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ridx_q      <= ridx_d;
      timer_q     <= timer_d;
      done_q      <= done_d;
      error_q     <= error_d;
      opcode_q    <= opcode_d;
      save_data_q <= save_data_d;
      start_q     <= start_d;
      hps_busy_q  <= hps_busy_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.host_rdata   = rdata_q;
  assign bus.matrix1_data = m1_q;
  assign bus.matrix2_data = m2_q;
  assign bus.instruction  = instr_q;
  assign bus.save_data    = save_data_q;
  assign bus.start        = start_q;
  assign bus.hps_busy     = hps_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hps_link_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_link_master
// Purpose  : Directed self-checking bench for hps_link_master. A behavioural
//            receiver answers the link; each scenario task checks its own
//            expected values inline.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_hps_link_master;
  import coproc_pkg::*;

  logic clk = 1'b0;
  logic rst;

  hps_link_master_if bus ();

  hps_link_master #(.WORDS(7), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [31:0] a_words [7];
  logic [31:0] b_words [7];
  logic [31:0] acc_a   [7];
  logic [31:0] acc_b   [7];
  int          acc_n, start_n, cyc_n, held_n;
  logic        ann_save, save_after, start_timely, busy_start, busy_bad, busy_after;
  logic [31:0] ann_m1, ann_m2;
  logic [5:0]  ann_instr, instr_seen;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    bus.host_wr    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    step();
    bus.host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [4:0] a, output logic [31:0] d);
    bus.host_rd   = 1'b1;
    bus.host_addr = a;
    step();
    bus.host_rd = 1'b0;
    d = bus.host_rdata;
  endtask

  task automatic clear_inputs();
    bus.host_wr = 0; bus.host_rd = 0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.fpga_wait = 0; bus.fpga_ready = 0; bus.result_data = '0;
    bus.result_valid = 0; bus.processing_done = 0;
  endtask

  task automatic load_banks();
    for (int k = 0; k < 7; k++) begin
      a_words[k] = 32'h01010101 + k;
      b_words[k] = 32'h10 + k;
      host_write(ADDR_A_BASE + 5'(k), a_words[k]);
      host_write(ADDR_B_BASE + 5'(k), b_words[k]);
    end
  endtask

  // Receiver model. Entered in the ANNOUNCE cycle (right after go is sampled).
  // mode 0: full transaction; mode 1: never raise fpga_ready;
  // mode 2: assert rst after 3 result captures.
  task automatic drive_txn(input int mode, input int stall_at, input int stall_len,
                           input bit lockout);
    int stall_left;
    int lock_phase;
    bit w;
    stall_left = stall_len;
    lock_phase = 0;
    acc_n = 0; start_n = 0; cyc_n = 0; held_n = 0; busy_bad = 0;
    ann_save  = bus.save_data;
    ann_m1    = bus.matrix1_data;
    ann_m2    = bus.matrix2_data;
    ann_instr = bus.instruction;
    step();
    while (acc_n < 7 && cyc_n < 40) begin
      cyc_n++;
      bus.host_wr = 1'b0;
      if (lockout && acc_n == 3 && lock_phase == 0) begin
        bus.host_wr = 1'b1; bus.host_addr = ADDR_A_BASE; bus.host_wdata = 32'hDEAD;
        lock_phase = 1;
      end else if (lockout && lock_phase == 1) begin
        bus.host_wr = 1'b1; bus.host_addr = ADDR_CTRL; bus.host_wdata = 32'h7F;
        lock_phase = 2;
      end
      w = (acc_n == stall_at) && (stall_left > 0);
      if (w) begin
        stall_left--;
        if (bus.save_data === 1'b1 && bus.matrix1_data === a_words[stall_at] &&
            bus.matrix2_data === b_words[stall_at]) held_n++;
      end else if (bus.save_data === 1'b1) begin
        acc_a[acc_n] = bus.matrix1_data;
        acc_b[acc_n] = bus.matrix2_data;
        acc_n++;
      end
      bus.fpga_wait = w;
      if (bus.start === 1'b1) start_n++;
      step();
    end
    bus.fpga_wait = 1'b0;
    bus.host_wr   = 1'b0;
    save_after = bus.save_data;
    instr_seen = bus.instruction;
    if (mode == 1) return;
    repeat (2) begin
      if (bus.start === 1'b1) start_n++;
      step();
    end
    bus.fpga_ready = 1'b1;
    step();
    bus.fpga_ready = 1'b0;
    start_timely = (bus.start === 1'b1);
    busy_start   = bus.hps_busy;
    if (bus.start === 1'b1) start_n++;
    step();
    for (int k = 0; k < 7; k++) begin
      if (mode == 2 && k == 3) begin
        rst = 1'b1;
        #1;
        return;
      end
      bus.result_valid = 1'b1;
      bus.result_data  = 32'hA0 + k;
      if (bus.hps_busy !== 1'b0) busy_bad = 1'b1;
      if (bus.start === 1'b1) start_n++;
      step();
    end
    bus.result_valid = 1'b0;
    busy_after = bus.hps_busy;
    bus.processing_done = 1'b1;
    step();
    bus.processing_done = 1'b0;
    if (bus.start === 1'b1) start_n++;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.save_data !== 1'b0) $display("FAIL reset_save_data got %b want 0", bus.save_data); else passed++;
    checks++; if (bus.start !== 1'b0) $display("FAIL reset_start got %b want 0", bus.start); else passed++;
    checks++; if (bus.hps_busy !== 1'b1) $display("FAIL reset_hps_busy got %b want 1", bus.hps_busy); else passed++;
    checks++; if (bus.matrix1_data !== 32'h0) $display("FAIL reset_matrix1 got %h want 0", bus.matrix1_data); else passed++;
    checks++; if (bus.matrix2_data !== 32'h0) $display("FAIL reset_matrix2 got %h want 0", bus.matrix2_data); else passed++;
    checks++; if (bus.instruction !== 6'h0) $display("FAIL reset_instruction got %h want 0", bus.instruction); else passed++;
    checks++; if (bus.host_rdata !== 32'h0) $display("FAIL reset_host_rdata got %h want 0", bus.host_rdata); else passed++;
    @(negedge clk);
    rst = 1'b0;
    step();
    host_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0) $display("FAIL reset_status got %h want 0", d); else passed++;
  endtask

  task automatic test_full();
    logic [31:0] d;
    load_banks();
    host_write(ADDR_CTRL, 32'h0B);
    drive_txn(0, -1, 0, 1'b0);
    checks++; if (ann_save !== 1'b1 || ann_m1 !== a_words[0] || ann_m2 !== b_words[0])
      $display("FAIL full_announce got save=%b a=%h b=%h want 1 %h %h", ann_save, ann_m1, ann_m2, a_words[0], b_words[0]); else passed++;
    checks++; if (ann_instr !== 6'h05) $display("FAIL full_instruction got %h want 05", ann_instr); else passed++;
    checks++; if (acc_n !== 7) $display("FAIL full_accept_count got %0d want 7", acc_n); else passed++;
    checks++; if (cyc_n !== 7) $display("FAIL full_accept_cycles got %0d want 7", cyc_n); else passed++;
    for (int k = 0; k < 7; k++) begin
      checks++; if (acc_a[k] !== a_words[k] || acc_b[k] !== b_words[k])
        $display("FAIL full_word%0d got %h/%h want %h/%h", k, acc_a[k], acc_b[k], a_words[k], b_words[k]); else passed++;
    end
    checks++; if (save_after !== 1'b0) $display("FAIL full_save_drop got %b want 0", save_after); else passed++;
    checks++; if (start_timely !== 1'b1 || busy_start !== 1'b0)
      $display("FAIL full_start_timing got start=%b busy=%b want 1 0", start_timely, busy_start); else passed++;
    checks++; if (start_n !== 1) $display("FAIL full_start_pulses got %0d want 1", start_n); else passed++;
    checks++; if (busy_bad !== 1'b0) $display("FAIL full_busy_collect got %b want 0", busy_bad); else passed++;
    checks++; if (busy_after !== 1'b1) $display("FAIL full_busy_after got %b want 1", busy_after); else passed++;
    for (int k = 0; k < 7; k++) begin
      host_read(ADDR_R_BASE + 5'(k), d);
      checks++; if (d !== 32'hA0 + k) $display("FAIL full_result%0d got %h want %h", k, d, 32'hA0 + k); else passed++;
    end
    host_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h2) $display("FAIL full_status got %h want 2", d); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] d;
    host_write(ADDR_CTRL, 32'h0B);
    drive_txn(0, 2, 3, 1'b0);
    checks++; if (held_n !== 3) $display("FAIL stall_held got %0d want 3", held_n); else passed++;
    checks++; if (acc_n !== 7) $display("FAIL stall_accept_count got %0d want 7", acc_n); else passed++;
    checks++; if (cyc_n !== 10) $display("FAIL stall_cycles got %0d want 10", cyc_n); else passed++;
    for (int k = 0; k < 7; k++) begin
      checks++; if (acc_a[k] !== a_words[k] || acc_b[k] !== b_words[k])
        $display("FAIL stall_word%0d got %h/%h want %h/%h", k, acc_a[k], acc_b[k], a_words[k], b_words[k]); else passed++;
    end
    host_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h2) $display("FAIL stall_status got %h want 2", d); else passed++;
  endtask

  task automatic test_busy_lockout();
    logic [31:0] d;
    host_write(ADDR_CTRL, 32'h0B);
    drive_txn(0, -1, 0, 1'b1);
    checks++; if (acc_n !== 7) $display("FAIL lock_accept_count got %0d want 7", acc_n); else passed++;
    checks++; if (acc_a[0] !== a_words[0] || acc_a[6] !== a_words[6])
      $display("FAIL lock_words got %h..%h want %h..%h", acc_a[0], acc_a[6], a_words[0], a_words[6]); else passed++;
    checks++; if (instr_seen !== 6'h05) $display("FAIL lock_instruction got %h want 05", instr_seen); else passed++;
    checks++; if (start_n !== 1) $display("FAIL lock_start_pulses got %0d want 1", start_n); else passed++;
    host_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h2) $display("FAIL lock_status got %h want 2", d); else passed++;
    host_read(ADDR_A_BASE, d);
    checks++; if (d !== a_words[0]) $display("FAIL lock_a0 got %h want %h", d, a_words[0]); else passed++;
  endtask

  task automatic test_unmapped_stray();
    logic [31:0] d;
    bus.result_valid = 1'b1;
    bus.result_data  = 32'h5555;
    repeat (3) step();
    bus.result_valid = 1'b0;
    host_read(ADDR_R_BASE, d);
    checks++; if (d !== 32'hA0) $display("FAIL stray_result0 got %h want a0", d); else passed++;
    host_read(ADDR_R_BASE + 5'd6, d);
    checks++; if (d !== 32'hA6) $display("FAIL stray_result6 got %h want a6", d); else passed++;
    host_read(5'd20, d);
    checks++; if (d !== 32'h0) $display("FAIL unmapped_20 got %h want 0", d); else passed++;
    host_read(ADDR_R_BASE + 5'd1, d);
    host_read(5'd7, d);
    checks++; if (d !== 32'h0) $display("FAIL unmapped_7 got %h want 0", d); else passed++;
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    host_write(ADDR_CTRL, 32'h0B);
    drive_txn(1, -1, 0, 1'b0);
    checks++; if (acc_n !== 7) $display("FAIL timeout_accept_count got %0d want 7", acc_n); else passed++;
    repeat (15) step();
    host_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h1) $display("FAIL timeout_status_cycle16 got %h want 1", d); else passed++;
    host_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h4) $display("FAIL timeout_status got %h want 4", d); else passed++;
    checks++; if (bus.save_data !== 1'b0 || bus.start !== 1'b0 || bus.hps_busy !== 1'b1)
      $display("FAIL timeout_outputs got save=%b start=%b busy=%b want 0 0 1", bus.save_data, bus.start, bus.hps_busy); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    host_write(ADDR_CTRL, 32'h0B);
    drive_txn(2, -1, 0, 1'b0);
    checks++; if (bus.save_data !== 1'b0 || bus.start !== 1'b0 || bus.hps_busy !== 1'b1)
      $display("FAIL rstmid_ctrl got save=%b start=%b busy=%b want 0 0 1", bus.save_data, bus.start, bus.hps_busy); else passed++;
    checks++; if (bus.matrix1_data !== 32'h0 || bus.matrix2_data !== 32'h0 || bus.instruction !== 6'h0)
      $display("FAIL rstmid_data got %h %h %h want 0 0 0", bus.matrix1_data, bus.matrix2_data, bus.instruction); else passed++;
    checks++; if (bus.host_rdata !== 32'h0) $display("FAIL rstmid_rdata got %h want 0", bus.host_rdata); else passed++;
    clear_inputs();
    #2;
    rst = 1'b0;
    step();
    host_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0) $display("FAIL rstmid_status got %h want 0", d); else passed++;
    for (int k = 0; k < 3; k++) begin
      host_read(ADDR_R_BASE + 5'(k), d);
      checks++; if (d !== 32'h0) $display("FAIL rstmid_result%0d got %h want 0", k, d); else passed++;
    end
    step();
    checks++; if (bus.save_data !== 1'b0 || bus.start !== 1'b0)
      $display("FAIL rstmid_quiet got save=%b start=%b want 0 0", bus.save_data, bus.start); else passed++;
  endtask

  initial begin
    test_reset();
    test_full();
    test_stall();
    test_busy_lockout();
    test_unmapped_stray();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/hps_link_master.md
# hps_link_master

Host-side end of the HPS↔FPGA matrix coprocessor link. It holds two 7-word operand banks and a 7-word result bank that the HPS accesses through a simple register port. On a `go` command it runs the full link transaction with the coprocessor buffer:

- stream the operand words,
- issue `start`,
- collect the result words,
- wait for completion.

It then reports status back to the HPS.

## Interface
Parameters:
- `WORDS`, 7: words per 5×5×8-bit matrix.
- `TIMEOUT_CYCLES`, 4096: maximum cycles spent in any wait state before the transaction aborts.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `host_wr`  in  1  register write strobe.
- `host_rd`  in  1  register read strobe.
- `host_addr`  in  5  register address.
- `host_wdata`  in  32  write data.
- `host_rdata`  out  32  read data, valid 1 cycle after `host_rd`.
- `matrix1_data`  out  32  operand A word.
- `matrix2_data`  out  32  operand B word.
- `instruction`  out  6  opcode, held for the whole transaction.
- `save_data`  out  1  operand word valid.
- `start`  out  1  process command.
- `hps_busy`  out  1  result words cannot be accepted.
- `fpga_wait`  in  1  receiver stall.
- `fpga_ready`  in  1  receiver holds all operands.
- `result_data`  in  32  result word.
- `result_valid`  in  1  result word valid.
- `processing_done`  in  1  receiver finished.

## Operation
Address map:
- 0–6: A words.
- 8–14: B words.
- 16: CTRL. Write bit0 = `go`, bits 6:1 = opcode.
- 17: STATUS, read-only. bit0 busy, bit1 done, bit2 error.
- 24–30: result words, read-only.
- Any other address reads 0; writes to it are ignored.

Host-side rules:
- Writes to A, B or CTRL while busy are ignored.
- A `go` while busy is ignored.
- `go` clears the done and error flags, latches the opcode, and sets busy.

State machine:
- IDLE:
  - `save_data=0`, `start=0`, `hps_busy=1`.
  - On `go`, go to ANNOUNCE.
- ANNOUNCE, 1 cycle:
  - `save_data=1`, word 0 driven on the data outputs.
  - The word is not counted.
  - Go to SEND.
- SEND:
  - `save_data=1`, word `idx` driven.
  - A word is accepted in any cycle with `save_data && !fpga_wait`; `idx` then increments.
  - After the acceptance with `idx==WORDS-1`, `save_data` drops and the state goes to WAIT_READY.
- WAIT_READY:
  - On `fpga_ready=1`, go to START.
- START, 1 cycle:
  - `start=1`, `hps_busy=0`, `ridx=0`.
  - Go to COLLECT.
- COLLECT:
  - `hps_busy=0`.
  - Each cycle with `result_valid=1` writes `result_data` into result[`ridx`] and increments `ridx`.
  - After the 7th capture, `hps_busy=1` and the state goes to WAIT_DONE.
- WAIT_DONE:
  - On `processing_done=1`, set done, clear busy, go to IDLE.
- Timeout:
  - A timer counts cycles spent in SEND, WAIT_READY, COLLECT and WAIT_DONE.
  - It resets on every state change and on every accepted or captured word.
  - When it reaches `TIMEOUT_CYCLES`, set error, clear busy, force `save_data=0` and `start=0`, and go to IDLE.
- Other rules:
  - `result_valid` outside COLLECT is ignored.
  - `processing_done` arriving before WAIT_DONE is ignored.
  - `instruction` outputs the latched opcode in all non-IDLE states.

## Timing
- All outputs are registered.
- Reset values:
  - `save_data=0`, `start=0`, `hps_busy=1`.
  - `matrix1_data`, `matrix2_data`, `instruction`, `host_rdata` all 0.
  - Banks and flags are cleared.
- Reset mid-transaction returns to IDLE immediately; no further link activity occurs.
- `go` is sampled at cycle t: ANNOUNCE at t+1, first SEND at t+2.
- With `fpga_wait=0` throughout, the 7 words are accepted at t+2 … t+8.
- `fpga_wait` high stalls SEND; the data outputs hold their value while stalled.
- `start` occurs 1 cycle after `fpga_ready` is sampled high.
- Result-bank reads during COLLECT return the current contents.

## Structure
- Package `coproc_pkg` holds:
  - `WORDS`,
  - the address constants,
  - the state enum `link_state_t`.
- Sub-module `word_bank`: 7×32 register file with 1 sync write port, 1 async read port, and async clear. Instantiated three times (A, B, result).

## Test plan
- **Full transaction:**
  - Stimulus: A words = 0x01010101+k, B words = 0x10+k, opcode 0x05, `go`; receiver model keeps `fpga_wait=0` and returns results 0xA0+k.
  - Required: 7 accepted word pairs in order, one `start` pulse, result bank = 0xA0..0xA6, STATUS=0b010.
- **Stall:**
  - Stimulus: `fpga_wait` high for 3 cycles at word 2.
  - Required: word 2 held for 3 cycles, still exactly 7 accepts, no duplicate words.
- **Timeout:**
  - Stimulus: `fpga_ready` never asserted, `TIMEOUT_CYCLES=16`.
  - Required: STATUS=0b100 after 16 cycles in WAIT_READY, `save_data=0`, `start=0`.
- **Busy lockout:**
  - Stimulus: during SEND, write A[0]=0xDEAD and CTRL `go`.
  - Required: A[0] unchanged, no restart, transaction completes normally.
- **Reset mid-operation:**
  - Stimulus: assert `rst` during COLLECT after 3 captures.
  - Required: all outputs take their reset values immediately, STATUS=0, result bank=0.
- **Unmapped and stray:**
  - Stimulus: read address 20; drive `result_valid` while in IDLE.
  - Required: `host_rdata=0`, result bank unchanged.
